// File: rtl/pic24_readback_buf_if.sv
// Readback buffer bus: programmer word input, byte-wide sink handshake,
// and FIFO status/overflow control. The slave modport is the buffer side.
interface pic24_readback_buf_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic                  dvalid;
  logic [15:0]           din;
  logic [7:0]            tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [DEPTH_LOG2:0]   count;
  logic                  empty;
  logic                  full;
  logic                  overflow;
  logic                  clr_ovf;

  modport slave (
    input  dvalid, din, tx_ready, clr_ovf,
    output tx_data, tx_valid, count, empty, full, overflow
  );

  modport master (
    output dvalid, din, tx_ready, clr_ovf,
    input  tx_data, tx_valid, count, empty, full, overflow
  );
endinterface

// File: rtl/pic24_readback_buf.sv
// PIC24 readback buffer: FIFOs 16-bit readback words and serializes each
// as low byte then high byte to a valid/ready byte sink.
// Optional macro PIC24_RB_SYNC_EN prefixes every word with SYNC_BYTE.
//
// state | meaning
// IDLE  | nothing held, tx_valid low
// SYNC  | presenting SYNC_BYTE for the held word (PIC24_RB_SYNC_EN only)
// LO    | presenting hold[7:0]
// HI    | presenting hold[15:8]; next word popped on accept if available
module pic24_readback_buf #(
  parameter int         DEPTH_LOG2 = 4,
  parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
  input logic                 clk,
  input logic                 rst,
  pic24_readback_buf_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, SYNC, LO, HI} state_t;

`ifdef PIC24_RB_SYNC_EN
  localparam state_t FIRST = SYNC;
`else
  localparam state_t FIRST = LO;
  logic [7:0] unused_sync_byte;
  assign unused_sync_byte = SYNC_BYTE;
`endif

  state_t state, state_nxt;

  logic [15:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic [15:0]           hold;
  logic                  overflow;
  logic                  empty, full;
  logic                  wr_en, drop, pop;

  // full/empty come from the registered count, so a write while full is
  // dropped even if a pop frees a slot on the same edge
  assign empty = (count == '0);
  assign full  = (count == (DEPTH_LOG2+1)'(DEPTH));
  assign wr_en = bus.dvalid && !full;
  assign drop  = bus.dvalid && full;
  assign pop   = !empty && ((state == IDLE) || (state == HI && bus.tx_ready));

  // FIFO storage write; contents need no reset since count guards reads
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= bus.din;
  end

  // FIFO pointers, occupancy and sticky overflow (set beats clear)
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop)             overflow <= 1'b1;
      else if (bus.clr_ovf) overflow <= 1'b0;
    end
  end

  // FSM state and hold register; reset abandons any held word
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      hold  <= '0;
    end else begin
      state <= state_nxt;
      if (pop) hold <= mem[rd_ptr];
    end
  end

  // next-state: advance one byte per accepted handshake
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (!empty) state_nxt = FIRST;
      SYNC: if (bus.tx_ready) state_nxt = LO;
      LO:   if (bus.tx_ready) state_nxt = HI;
      HI:   if (bus.tx_ready) state_nxt = empty ? IDLE : FIRST;
      default: state_nxt = IDLE;
    endcase
  end

  // outputs: byte select from state and hold register
  always_comb begin
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    case (state)
`ifdef PIC24_RB_SYNC_EN
      SYNC: begin bus.tx_valid = 1'b1; bus.tx_data = SYNC_BYTE;  end
`endif
      LO:   begin bus.tx_valid = 1'b1; bus.tx_data = hold[7:0];  end
      HI:   begin bus.tx_valid = 1'b1; bus.tx_data = hold[15:8]; end
      default: ;
    endcase
    bus.count    = count;
    bus.empty    = empty;
    bus.full     = full;
    bus.overflow = overflow;
  end
endmodule

// File: tb/tb_pic24_readback_buf.sv
// Scoreboard bench for pic24_readback_buf: expected bytes are queued as
// words are driven and popped by a monitor on every accepted byte.
module tb_pic24_readback_buf;
  localparam int DL2 = 4;
`ifdef PIC24_RB_SYNC_EN
  localparam int BPW = 3;
`else
  localparam int BPW = 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pic24_readback_buf_if #(.DEPTH_LOG2(DL2)) bus ();

  pic24_readback_buf #(.DEPTH_LOG2(DL2), .SYNC_BYTE(8'hA5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] sb [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_word(input logic [15:0] w);
`ifdef PIC24_RB_SYNC_EN
    sb.push_back(8'hA5);
`endif
    sb.push_back(w[7:0]);
    sb.push_back(w[15:8]);
  endtask

  // drive one dvalid strobe; expected bytes are queued only if accepted
  task automatic strobe(input logic [15:0] w, input bit expect_keep);
    bus.dvalid = 1'b1;
    bus.din    = w;
    if (expect_keep) push_word(w);
    @(posedge clk); #1;
    bus.dvalid = 1'b0;
  endtask

  task automatic drain(input int max);
    int n = 0;
    while ((sb.size() != 0 || bus.tx_valid) && n < max) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_done", (n < max), 1);
  endtask

  // monitor: compare every accepted byte and check held bytes stay put
  logic       last_v = 1'b0, last_r = 1'b0, last_rst = 1'b1;
  logic [7:0] last_d = 8'h00;
  always @(negedge clk) begin
    if (!rst && !last_rst && last_v && !last_r)
      check("hold_stable", {23'd0, bus.tx_valid, bus.tx_data}, {23'd0, 1'b1, last_d});
    if (!rst && bus.tx_valid && bus.tx_ready) begin
      if (sb.size() == 0) check("unexpected_byte", {24'd0, bus.tx_data}, 32'hFFFF_FFFF);
      else                check("byte", {24'd0, bus.tx_data}, {24'd0, sb.pop_front()});
    end
    last_v   = bus.tx_valid;
    last_r   = bus.tx_ready;
    last_d   = bus.tx_data;
    last_rst = rst;
  end

  initial begin
    int run;
    bus.dvalid   = 1'b1;
    bus.din      = 16'h1234;
    bus.tx_ready = 1'b1;
    bus.clr_ovf  = 1'b0;

    // reset held 3 cycles with dvalid active
    repeat (3) @(posedge clk);
    #1;
    check("rst_count", bus.count, 0);
    check("rst_tx_valid", bus.tx_valid, 0);
    check("rst_tx_data", bus.tx_data, 0);
    check("rst_overflow", bus.overflow, 0);
    check("rst_empty", bus.empty, 1);
    check("rst_full", bus.full, 0);
    rst = 1'b0;
    bus.dvalid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("post_rst_idle", bus.tx_valid, 0);

    // single word, latency and byte order
    strobe(16'hBEEF, 1);
    check("lat_e0", bus.tx_valid, 0);
    @(posedge clk); #1;
    check("lat_e1", bus.tx_valid, 1);
    check("lat_first_byte", bus.tx_data, (BPW == 3) ? 32'hA5 : 32'hEF);
    drain(20);
    check("single_empty", bus.empty, 1);
    check("single_idle", bus.tx_valid, 0);

    // backpressure with toggling ready
    bus.tx_ready = 1'b0;
    strobe(16'h0102, 1);
    strobe(16'h0304, 1);
    strobe(16'h0506, 1);
    for (int i = 0; i < 30; i++) begin
      bus.tx_ready = ~bus.tx_ready;
      @(posedge clk); #1;
    end
    bus.tx_ready = 1'b1;
    drain(40);

    // overflow: 1 word held + 16 in FIFO, then drops
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 17; i++) strobe(16'(i), 1);
    check("ovf_full", bus.full, 1);
    check("ovf_count", bus.count, 16);
    check("ovf_not_yet", bus.overflow, 0);
    strobe(16'h0011, 0);
    check("ovf_set", bus.overflow, 1);
    bus.clr_ovf = 1'b1;
    strobe(16'h0012, 0);
    check("ovf_set_wins", bus.overflow, 1);
    @(posedge clk); #1;
    bus.clr_ovf = 1'b0;
    check("ovf_cleared", bus.overflow, 0);
    bus.tx_ready = 1'b1;
    drain(200);
    check("ovf_drained_empty", bus.count, 0);

    // back-to-back words: no tx_valid gap
    strobe(16'h55AA, 1);
    strobe(16'h1357, 1);
    run = 0;
    while (bus.tx_valid && run < 20) begin
      run++;
      @(posedge clk); #1;
    end
    check("b2b_run", run, 2 * BPW);
    drain(20);

    // reset mid-transfer abandons held and queued words
    bus.tx_ready = 1'b0;
    strobe(16'h7788, 0);
    strobe(16'h99AA, 0);
    repeat (2) @(posedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_valid", bus.tx_valid, 0);
    check("midrst_count", bus.count, 0);
    bus.tx_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("midrst_silent", bus.tx_valid, 0);

    check("sb_leftover", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
